// File: rtl/matrix_printer_pkg.sv
// matrix_defs: dimensions, ASCII constants, printer states and BCD helpers shared by the matrix blocks
package matrix_defs;
    localparam int DEF_MAX_DIM = 5;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int BCD_DIGITS  = 10;
    localparam int BCD_W       = 4 * BCD_DIGITS;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;
    typedef enum logic [3:0] {
        S_IDLE, S_RD_ADDR, S_RD_WAIT, S_CONV, S_EMIT_SIGN,
        S_EMIT_DIG, S_EMIT_SEP, S_EMIT_CR, S_EMIT_LF, S_DONE
    } printer_state_t;
    // ASCII character of BCD digit idx (0 = least significant)
    function automatic logic [7:0] digit_char(input logic [BCD_W-1:0] bcd, input logic [3:0] idx);
        return CHAR_ZERO | (8'(bcd >> {idx, 2'b00}) & 8'h0F);
    endfunction
    // index of the most significant non-zero digit; 0 for a zero value so it still prints '0'
    function automatic logic [3:0] top_digit(input logic [BCD_W-1:0] bcd);
        top_digit = 4'd0;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (bcd[i*4 +: 4] != 4'd0) top_digit = 4'(i);
    endfunction
endpackage

// File: rtl/matrix_printer_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to 10-digit BCD converter
// Ports: clk, rst_n (async, active low); i_start loads i_bin (32-bit);
//        o_done pulses once 32 shifts later (33 cycles after i_start);
//        o_bcd (40-bit, 10 digits) holds the result until the next i_start.
module bin2bcd_seq
    import matrix_defs::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [31:0]      i_bin,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);
    logic [31:0]      r_sh;
    logic [BCD_W-1:0] r_bcd;
    logic [BCD_W-1:0] w_adj;
    logic [5:0]       r_cnt;
    logic             r_done;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++)
            w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] >= 4'd5 ? r_bcd[i*4 +: 4] + 4'd3 : r_bcd[i*4 +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_sh   <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= 6'd32;
            r_done <= 1'b0;
        end else if (r_cnt != 6'd0) begin
            {r_bcd, r_sh} <= {w_adj, r_sh} << 1;
            r_cnt         <= r_cnt - 6'd1;
            r_done        <= r_cnt == 6'd1;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;
endmodule

// File: rtl/matrix_printer.sv
// matrix_printer: streams an m x n matrix from storage as ASCII decimal text over a byte handshake
// Ports: clk, rst_n (async, active low); i_start_print/i_base_addr/i_m/i_n start a print;
//        o_busy, o_print_done, o_dim_err report status; o_rd_addr/i_rd_data form the
//        synchronous storage read port (1-cycle latency); o_tx_data/o_tx_valid/i_tx_ready
//        feed the UART transmitter.
// Config: PRINTER_SIGNED_EN defined prints two's-complement values with a leading '-';
//         otherwise every element prints as unsigned decimal.
module matrix_printer
    import matrix_defs::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_DIM = DEF_MAX_DIM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start_print,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [31:0]       i_m,
    input  logic [31:0]       i_n,
    output logic              o_busy,
    output logic              o_print_done,
    output logic              o_dim_err,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready
);
    localparam int CNT_W = $clog2(MAX_DIM + 1);

    printer_state_t    r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_row, r_col, r_m_last, r_n_last;
    logic [3:0]        r_idx;
    logic              r_neg, r_busy, r_done, r_dim_err, r_tx_valid;
    logic [7:0]        r_tx_data;
    logic [31:0]       w_val, w_mag;
    logic              w_neg, w_bad, w_last_col, w_conv_done;
    logic [BCD_W-1:0]  w_bcd;
    logic [3:0]        w_top;

    assign w_val = 32'(i_rd_data);
`ifdef PRINTER_SIGNED_EN
    assign w_neg = w_val[31];
`else
    assign w_neg = 1'b0;
`endif
    // 32-bit negate: 32'h8000_0000 maps onto itself, which reads as 2147483648 unsigned
    assign w_mag      = w_neg ? 32'd0 - w_val : w_val;
    assign w_bad      = i_m == 32'd0 || i_m > 32'(MAX_DIM) || i_n == 32'd0 || i_n > 32'(MAX_DIM);
    assign w_last_col = r_col == r_n_last;
    assign w_top      = top_digit(w_bcd);

    // the converter loads while the read data is valid, so CONV spans its 33-cycle latency
    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (r_state == S_RD_WAIT),
        .i_bin   (w_mag),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    // each emit state is entered with its byte already loaded; leaving it on acceptance
    // loads the next byte, or drops valid when the next state reads storage or finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_m_last   <= '0;
            r_n_last   <= '0;
            r_idx      <= '0;
            r_neg      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dim_err  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_done    <= 1'b0;
            r_dim_err <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (i_start_print && w_bad) begin
                        r_done    <= 1'b1;
                        r_dim_err <= 1'b1;
                    end else if (i_start_print) begin
                        r_busy   <= 1'b1;
                        r_ptr    <= i_base_addr;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_m_last <= CNT_W'(i_m - 32'd1);
                        r_n_last <= CNT_W'(i_n - 32'd1);
                        r_state  <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_neg   <= w_neg;
                    r_state <= S_CONV;
                end
                S_CONV: if (w_conv_done) begin
                    r_tx_valid <= 1'b1;
                    r_idx      <= w_top;
                    r_tx_data  <= r_neg ? CHAR_MINUS : digit_char(w_bcd, w_top);
                    r_state    <= r_neg ? S_EMIT_SIGN : S_EMIT_DIG;
                end
                S_EMIT_SIGN: if (i_tx_ready) begin
                    r_tx_data <= digit_char(w_bcd, r_idx);
                    r_state   <= S_EMIT_DIG;
                end
                S_EMIT_DIG: if (i_tx_ready && r_idx != 4'd0) begin
                    r_idx     <= r_idx - 4'd1;
                    r_tx_data <= digit_char(w_bcd, r_idx - 4'd1);
                end else if (i_tx_ready) begin
                    r_tx_data <= w_last_col ? CHAR_CR : CHAR_SPACE;
                    r_state   <= w_last_col ? S_EMIT_CR : S_EMIT_SEP;
                end
                S_EMIT_SEP: if (i_tx_ready) begin
                    r_tx_valid <= 1'b0;
                    r_col      <= r_col + 1'b1;
                    r_ptr      <= r_ptr + 1'b1;
                    r_state    <= S_RD_ADDR;
                end
                S_EMIT_CR: if (i_tx_ready) begin
                    r_tx_data <= CHAR_LF;
                    r_state   <= S_EMIT_LF;
                end
                S_EMIT_LF: if (i_tx_ready && r_row == r_m_last) begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= S_DONE;
                end else if (i_tx_ready) begin
                    r_tx_valid <= 1'b0;
                    r_row      <= r_row + 1'b1;
                    r_col      <= '0;
                    r_ptr      <= r_ptr + 1'b1;
                    r_state    <= S_RD_ADDR;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_print_done = r_done;
    assign o_dim_err    = r_dim_err;
    assign o_rd_addr    = r_ptr;
    assign o_tx_data    = r_tx_data;
    assign o_tx_valid   = r_tx_valid;
endmodule

// File: tb/tb_matrix_printer.sv
// tb_matrix_printer: scoreboard bench for matrix_printer (expected bytes queued per print, popped on each accepted byte)
module tb_matrix_printer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  base = 8'h00;
    logic [31:0] m = 32'd1;
    logic [31:0] n = 32'd1;
    logic [31:0] rd_data = 32'd0;
    logic [7:0]  rd_addr, tx_data;
    logic        tx_valid, busy, done, dim_err;
    logic [31:0] mem [256];
    logic [7:0]  q [$];
    int          n_vec = 0, n_err = 0, n_done = 0, n_valid = 0;
    bit          rand_rdy = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    matrix_printer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start_print (start),
        .i_base_addr   (base),
        .i_m           (m),
        .i_n           (n),
        .o_busy        (busy),
        .o_print_done  (done),
        .o_dim_err     (dim_err),
        .o_rd_addr     (rd_addr),
        .i_rd_data     (rd_data),
        .o_tx_data     (tx_data),
        .o_tx_valid    (tx_valid),
        .i_tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic string fmt(input logic [31:0] v);
`ifdef PRINTER_SIGNED_EN
        return $sformatf("%0d", $signed(v));
`else
        return $sformatf("%0d", v);
`endif
    endfunction

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", 32'(tx_data), 32'(prev_data));
        end
        if (tx_valid && tx_ready) begin
            if (q.size() == 0) check("byte", 32'(tx_data), 32'h100);
            else check("byte", 32'(tx_data), 32'(q.pop_front()));
        end
        if (done) n_done++;
        if (tx_valid) n_valid++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic pulse_start(input logic [7:0] b, input int mm, input int nn);
        base = b;
        m = 32'(mm);
        n = 32'(nn);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // lat > 0 checks the cycle (counted from the start cycle) in which done appears;
    // dup issues an extra start pulse in the middle of the print
    task automatic run(input logic [7:0] b, input int mm, input int nn, input bit err, input int lat, input bit dup);
        int k;
        int d0;
        d0 = n_done;
        pulse_start(b, mm, nn);
        for (k = 1; k < 40000 && !done; k++) begin
            start = dup && k == 60;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        if (lat > 0) check("done_cycle", 32'(k), 32'(lat));
        check("dim_err", 32'(dim_err), 32'(err));
        check("busy_at_done", 32'(busy), 32'd0);
        check("sb_left", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 32'(n_done - d0), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int v0;
        int k;
        string s;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dim_err", 32'(dim_err), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'(i + 1);
        expect_str("1 2\r\n3 4\r\n");
        run(8'h10, 2, 2, 1'b0, 151, 1'b0);

        mem[8'h20] = 32'h0000_0000;
        mem[8'h21] = 32'hFFFF_FFFF;
        mem[8'h22] = 32'h8000_0000;
`ifdef PRINTER_SIGNED_EN
        expect_str("0 -1 -2147483648\r\n");
        run(8'h20, 1, 3, 1'b0, 124, 1'b0);
`else
        expect_str("0 4294967295 2147483648\r\n");
        run(8'h20, 1, 3, 1'b0, 131, 1'b0);
`endif

        v0 = n_valid;
        run(8'h10, 0, 3, 1'b1, 1, 1'b0);
        run(8'h10, 2, 6, 1'b1, 1, 1'b0);
        run(8'h10, 6, 1, 1'b1, 1, 1'b0);
        check("rej_no_tx", 32'(n_valid - v0), 32'd0);

        mem[8'hFE] = 32'd7;
        mem[8'hFF] = 32'hFFFF_FFFB;
        mem[8'h00] = 32'd42;
        expect_str({fmt(32'd7), " ", fmt(32'hFFFF_FFFB), " ", fmt(32'd42), "\r\n"});
        run(8'hFE, 1, 3, 1'b0, 0, 1'b1);

        for (int i = 0; i < 25; i++) mem[8'h80 + i] = 32'd123456789;
        s = "";
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) s = {s, "123456789", c == 4 ? "\r\n" : " "};
        expect_str(s);
        rand_rdy = 1'b1;
        run(8'h80, 5, 5, 1'b0, 0, 1'b0);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        mem[8'h40] = 32'd987654321;
        mem[8'h41] = 32'd5;
        expect_str("987654321 5\r\n");
        pulse_start(8'h40, 1, 2);
        for (k = 0; k < 200 && !tx_valid; k++) begin
            @(posedge clk);
            #1;
        end
        check("emit_begun", 32'(tx_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_data", 32'(tx_data), 32'd0);
        check("abort_addr", 32'(rd_addr), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dim_err", 32'(dim_err), 32'd0);
        q.delete();
        v0 = n_done;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_no_done", 32'(n_done - v0), 32'd0);
        expect_str("987654321 5\r\n");
        run(8'h40, 1, 2, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
